// File: rtl/bf16_to_fixed_converter.sv
// Two-stage pipelined bf16 -> signed fixed-point converter with a saturation event counter.
// Define BF16_FIX_RNE_EN to round to nearest-even instead of truncating toward zero.
module bf16_to_fixed_converter #(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             clr_count,
  output logic [15:0]      sat_count
);

  // Wide enough to hold mant << OUT_W; larger shifts are clamped to all-ones.
  localparam int MAG_W  = OUT_W + 9;
  localparam int K_BIAS = 127 + 7 - FRAC_BITS;

  localparam logic [MAG_W-1:0] LIM     = MAG_W'(1) << (OUT_W - 1);
  localparam logic [MAG_W-1:0] LIM_M1  = LIM - MAG_W'(1);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MAX_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

  logic             s1_valid;
  cls_t             s1_cls;
  logic             s1_sign;
  logic [MAG_W-1:0] s1_mag;

  logic             s2_free;
  logic             in_fire;
  logic             out_fire;

  logic [7:0]       u_exp;
  logic [6:0]       u_frac;
  logic [7:0]       u_mant;
  int               u_k;
  int               u_nk;
  cls_t             u_cls;
  logic [MAG_W-1:0] u_mag;

  logic [MAG_W-1:0] r_mag;
  logic [OUT_W-1:0] nx_data;
  logic             nx_sat;

`ifdef BF16_FIX_RNE_EN
  logic             s1_guard;
  logic             s1_sticky;
  logic             u_guard;
  logic             u_sticky;
  logic [15:0]      u_ext;
`endif

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Stage 1: unpack, classify and align the magnitude.
  always_comb begin
    u_exp  = in_data[14:7];
    u_frac = in_data[6:0];
    u_mant = {1'b1, u_frac};
    u_k    = int'(u_exp) - K_BIAS;
    u_nk   = -u_k;
    u_mag  = '0;
`ifdef BF16_FIX_RNE_EN
    u_guard  = 1'b0;
    u_sticky = 1'b0;
    u_ext    = '0;
`endif
    if (u_exp == 8'h00)
      u_cls = CLS_ZERO;
    else if (u_exp == 8'hFF)
      u_cls = (u_frac == 7'd0) ? CLS_INF : CLS_NAN;
    else
      u_cls = CLS_NORM;

    if (u_k > OUT_W)
      u_mag = '1;
    else if (u_k >= 0)
      u_mag = MAG_W'(u_mant) << u_k[5:0];
    else if (u_nk <= 8) begin
`ifdef BF16_FIX_RNE_EN
      u_ext    = {u_mant, 8'h00} >> u_nk[3:0];
      u_mag    = MAG_W'(u_ext[15:8]);
      u_guard  = u_ext[7];
      u_sticky = |u_ext[6:0];
`else
      u_mag = MAG_W'(u_mant >> u_nk[3:0]);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_cls    <= CLS_ZERO;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
`ifdef BF16_FIX_RNE_EN
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
`endif
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_cls    <= u_cls;
      s1_sign   <= in_data[15];
      s1_mag    <= u_mag;
`ifdef BF16_FIX_RNE_EN
      s1_guard  <= u_guard;
      s1_sticky <= u_sticky;
`endif
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: round the magnitude, then saturate and apply the sign.
  always_comb begin
`ifdef BF16_FIX_RNE_EN
    r_mag = s1_mag + MAG_W'(s1_guard & (s1_sticky | s1_mag[0]));
`else
    r_mag = s1_mag;
`endif
    nx_data = '0;
    nx_sat  = 1'b0;
    case (s1_cls)
      CLS_INF: begin
        nx_sat  = 1'b1;
        nx_data = s1_sign ? MAX_NEG : MAX_POS;
      end
      CLS_NAN: nx_sat = 1'b1;
      CLS_NORM: begin
        if (!s1_sign) begin
          if (r_mag > LIM_M1) begin
            nx_sat  = 1'b1;
            nx_data = MAX_POS;
          end else begin
            nx_data = r_mag[OUT_W-1:0];
          end
        end else if (r_mag > LIM) begin
          nx_sat  = 1'b1;
          nx_data = MAX_NEG;
        end else begin
          nx_data = -r_mag[OUT_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= nx_data;
        out_sat  <= nx_sat;
      end
    end
  end

  // A clear coinciding with a counted transfer leaves that transfer counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_count <= '0;
    else if (clr_count)
      sat_count <= (out_fire && out_sat) ? 16'd1 : 16'd0;
    else if (out_fire && out_sat && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_bf16_to_fixed_converter.sv
// Self-checking bench for bf16_to_fixed_converter: real-arithmetic reference model,
// scoreboard compare on every output transfer, directed corner cases and random traffic.
module tb_bf16_to_fixed_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clr_count;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [15:0] out_data_a, sat_count_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [15:0] out_data_b, sat_count_b;

  int checks   = 0;
  int failures = 0;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic        stall_a = 1'b0;
  logic        stall_b = 1'b0;
  logic [32:0] held_a, held_b;
  logic        done;
  logic        saw_drop;

  always #5 clk = ~clk;

  bf16_to_fixed_converter #(.OUT_W(16), .FRAC_BITS(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a),
    .clr_count(clr_count), .sat_count(sat_count_a)
  );

  bf16_to_fixed_converter #(.OUT_W(16), .FRAC_BITS(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b),
    .clr_count(clr_count), .sat_count(sat_count_b)
  );

  // Returns {sat, 32-bit result zero-extended from ow bits}, from the real value of the operand.
  function automatic logic [32:0] model(input logic [15:0] x, input int ow, input int fb);
    logic        s;
    int          e, f;
    real         r, m, lim;
    longint      v;
    logic [31:0] maxpos, minneg, dat;
`ifdef BF16_FIX_RNE_EN
    real         fr;
`endif
    s      = x[15];
    e      = int'(x[14:7]);
    f      = int'(x[6:0]);
    maxpos = 32'((64'd1 << (ow - 1)) - 64'd1);
    minneg = 32'((64'd1 << ow) - (64'd1 << (ow - 1)));
    if (e == 0) return 33'd0;
    if (e == 255) begin
      if (f != 0) return {1'b1, 32'd0};
      return {1'b1, s ? minneg : maxpos};
    end
    r = real'(128 + f) * (2.0 ** real'(e - 134 + fb));
    m = $floor(r);
`ifdef BF16_FIX_RNE_EN
    fr = r - m;
    if (fr > 0.5 || (fr == 0.5 && ($floor(m / 2.0) * 2.0 != m))) m = m + 1.0;
`endif
    lim = 2.0 ** real'(ow - 1);
    if (!s && m > lim - 1.0) return {1'b1, maxpos};
    if (s && m > lim) return {1'b1, minneg};
    v = longint'(m);
    if (s) v = -v;
    dat = 32'(v & ((64'sd1 <<< ow) - 64'sd1));
    return {1'b0, dat};
  endfunction

  function automatic logic [15:0] randOperand();
    logic [7:0] e;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else               e = 8'($urandom_range(115, 150));
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one operand and holds it until accepted; returns #1 after the transfer edge.
  task automatic applyStimulus(input logic [15:0] d);
    int n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready_a) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 33'd0, 33'd1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || out_valid_a || out_valid_b) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 33'(qa.size() + qb.size()), 33'd0);
  endtask

  task automatic pulseClear();
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  // Scoreboard and hold-stability compare, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (out_valid_a && stall_a) checkOutput("hold_a", {out_sat_a, 16'h0, out_data_a}, held_a);
      if (out_valid_b && stall_b) checkOutput("hold_b", {out_sat_b, 16'h0, out_data_b}, held_b);
      if (out_valid_a && out_ready) begin
        if (qa.size() == 0) checkOutput("unexpected_out_a", {out_sat_a, 16'h0, out_data_a}, 33'h1_FFFF_FFFF);
        else checkOutput("out_a", {out_sat_a, 16'h0, out_data_a}, qa.pop_front());
      end
      if (out_valid_b && out_ready) begin
        if (qb.size() == 0) checkOutput("unexpected_out_b", {out_sat_b, 16'h0, out_data_b}, 33'h1_FFFF_FFFF);
        else checkOutput("out_b", {out_sat_b, 16'h0, out_data_b}, qb.pop_front());
      end
      stall_a = out_valid_a && !out_ready;
      stall_b = out_valid_b && !out_ready;
      held_a  = {out_sat_a, 16'h0, out_data_a};
      held_b  = {out_sat_b, 16'h0, out_data_b};
      if (in_valid && in_ready_a) qa.push_back(model(in_data, 16, 0));
      if (in_valid && in_ready_b) qb.push_back(model(in_data, 16, 8));
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_count = 1'b0; done = 1'b0;
    #1;
    checkOutput("rst_out_valid", 33'(out_valid_a), 33'd0);
    checkOutput("rst_out_data", {out_sat_a, 16'h0, out_data_a}, 33'd0);
    checkOutput("rst_sat_count", 33'(sat_count_a), 33'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 33'(in_ready_a), 33'd1);
    @(posedge clk);
    #1;

    // Pin the reference model to hand-computed values.
    checkOutput("pin_1p0", model(16'h3F80, 16, 0), 33'h0_0000_0001);
    checkOutput("pin_m123", model(16'hC2F6, 16, 0), 33'h0_0000_FF85);
    checkOutput("pin_negzero", model(16'h8000, 16, 0), 33'h0_0000_0000);
    checkOutput("pin_pos_sat", model(16'h4700, 16, 0), 33'h1_0000_7FFF);
    checkOutput("pin_neg_exact", model(16'hC700, 16, 0), 33'h0_0000_8000);
    checkOutput("pin_nan", model(16'h7FC0, 16, 0), 33'h1_0000_0000);
    checkOutput("pin_ninf", model(16'hFF80, 16, 0), 33'h1_0000_8000);
    checkOutput("pin_frac8", model(16'h3FC0, 16, 8), 33'h0_0000_0180);
`ifdef BF16_FIX_RNE_EN
    checkOutput("pin_rnd_1p5", model(16'h3FC0, 16, 0), 33'h0_0000_0002);
    checkOutput("pin_rnd_2p5", model(16'h4020, 16, 0), 33'h0_0000_0002);
    checkOutput("pin_rnd_m1p5", model(16'hBFC0, 16, 0), 33'h0_0000_FFFE);
`else
    checkOutput("pin_rnd_1p5", model(16'h3FC0, 16, 0), 33'h0_0000_0001);
    checkOutput("pin_rnd_2p5", model(16'h4020, 16, 0), 33'h0_0000_0002);
    checkOutput("pin_rnd_m1p5", model(16'hBFC0, 16, 0), 33'h0_0000_FFFF);
`endif

    // Latency: result visible two cycles after the transfer cycle.
    in_valid = 1'b1;
    in_data  = 16'h3F80;
    @(negedge clk);
    checkOutput("lat_accept", 33'(in_ready_a), 33'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_cycle1", 33'(out_valid_a), 33'd0);
    @(negedge clk);
    checkOutput("lat_cycle2", 33'(out_valid_a), 33'd1);
    @(posedge clk);
    #1;

    applyStimulus(16'hC2F6);
    applyStimulus(16'h0000);
    applyStimulus(16'h8000);
    waitDrain("drain_basic");

    pulseClear();
    applyStimulus(16'h4700);
    applyStimulus(16'hC700);
    applyStimulus(16'h7F80);
    applyStimulus(16'hFF80);
    applyStimulus(16'h7FC0);
    applyStimulus(16'h0001);
    waitDrain("drain_sat");
    checkOutput("sat_count_a_4", 33'(sat_count_a), 33'd4);
    checkOutput("sat_count_b_5", 33'(sat_count_b), 33'd5);

    applyStimulus(16'h3FC0);
    applyStimulus(16'h4020);
    applyStimulus(16'hBFC0);
    waitDrain("drain_round");

    // Backpressure: six back-to-back items, out_ready low for cycles 3..6.
    saw_drop = 1'b0;
    fork
      begin
        applyStimulus(16'h3F80);
        applyStimulus(16'h4000);
        applyStimulus(16'h4040);
        applyStimulus(16'h4080);
        applyStimulus(16'h40A0);
        applyStimulus(16'h40C0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (in_valid && !in_ready_a) saw_drop = 1'b1;
        end
      end
    join
    checkOutput("bp_in_ready_drop", 33'(saw_drop), 33'd1);
    waitDrain("drain_bp");

    // Random traffic with random backpressure.
    fork
      begin
        repeat (300) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(randOperand());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    waitDrain("drain_random");

    // Counter sticks at 0xFFFF.
    pulseClear();
    repeat (65537) applyStimulus(16'h7F80);
    waitDrain("drain_flood");
    checkOutput("sat_count_a_sticky", 33'(sat_count_a), 33'h0_0000_FFFF);
    checkOutput("sat_count_b_sticky", 33'(sat_count_b), 33'h0_0000_FFFF);

    applyStimulus(16'h7F80);
    @(posedge clk);
    #1 clr_count = 1'b1;
    @(posedge clk);
    #1 clr_count = 1'b0;
    checkOutput("clr_with_transfer", 33'(sat_count_a), 33'd1);
    pulseClear();
    checkOutput("clr_alone", 33'(sat_count_a), 33'd0);

    // Asynchronous reset with two items held.
    applyStimulus(16'h7F80);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_rst_count", 33'(sat_count_a), 33'd1);
    out_ready = 1'b0;
    applyStimulus(16'h4700);
    applyStimulus(16'h3F80);
    checkOutput("pre_rst_held", 33'(out_valid_a), 33'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 33'(out_valid_a), 33'd0);
    checkOutput("async_rst_count", 33'(sat_count_a), 33'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 33'(in_ready_a), 33'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_rst_no_out", 33'(out_valid_a), 33'd0);
    end

    applyStimulus(16'hC2F6);
    waitDrain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
